card_grid_renderer: RTL and testbench

//  Pixel generator for the memory game's 3x3 card board; sits directly upstream of font_rom.

---
 rtl/card_grid_renderer.sv | 174 +++++++++++++++++
 tb/tb_card_grid_renderer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_grid_renderer.sv
// rtl/card_grid_renderer.sv - 3x3 card board pixel generator feeding font_rom, 2-clock pixel-to-rgb latency
module card_grid_renderer #(
  parameter int GRID_X0      = 224,
  parameter int GRID_Y0      = 120,
  parameter int TILE_W       = 64,
  parameter int TILE_H       = 80,
  parameter int BORDER       = 2,
  parameter int GLYPH_XOFF   = 8,
  parameter int GLYPH_YOFF   = 8,
  parameter int BLINK_FRAMES = 30,
  parameter logic [7:0] C_BG   = 8'h00,
  parameter logic [7:0] C_BACK = 8'h03,
  parameter logic [7:0] C_FACE = 8'hFF,
  parameter logic [7:0] C_FG   = 8'h00,
  parameter logic [7:0] C_CUR  = 8'hFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic [35:0] card_vals,
  input  logic [8:0]  card_face_up,
  input  logic [3:0]  cursor,
  output logic [8:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic [7:0]  rgb
);

  localparam int GLYPH_W = 48;
  localparam int GLYPH_H = 64;
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] X0 = 10'(GRID_X0);
  localparam logic [9:0] X1 = 10'(GRID_X0 + TILE_W);
  localparam logic [9:0] X2 = 10'(GRID_X0 + 2 * TILE_W);
  localparam logic [9:0] X3 = 10'(GRID_X0 + 3 * TILE_W);
  localparam logic [9:0] Y0 = 10'(GRID_Y0);
  localparam logic [9:0] Y1 = 10'(GRID_Y0 + TILE_H);
  localparam logic [9:0] Y2 = 10'(GRID_Y0 + 2 * TILE_H);
  localparam logic [9:0] Y3 = 10'(GRID_Y0 + 3 * TILE_H);

  localparam logic [9:0] BRD      = 10'(BORDER);
  localparam logic [9:0] BRD_R    = 10'(TILE_W - BORDER);
  localparam logic [9:0] BRD_B    = 10'(TILE_H - BORDER);
  localparam logic [9:0] GX_LO    = 10'(GLYPH_XOFF);
  localparam logic [9:0] GX_HI    = 10'(GLYPH_XOFF + GLYPH_W);
  localparam logic [9:0] GY_LO    = 10'(GLYPH_YOFF);
  localparam logic [9:0] GY_HI    = 10'(GLYPH_YOFF + GLYPH_H);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // stage 0: tile decode by range comparison
  logic [1:0] col, row;
  logic [9:0] lx, ly;
  logic       in_x, in_y, in_grid, border, in_glyph;
  logic [3:0] tile_idx, val;
  logic [4:0] gcol, grow;
  logic       face_up, val_ok, cur_hit;

  always_comb begin
    col  = 2'd0;
    lx   = 10'd0;
    in_x = 1'b0;
    if (pixel_x >= X0 && pixel_x < X1) begin
      col = 2'd0; lx = pixel_x - X0; in_x = 1'b1;
    end else if (pixel_x >= X1 && pixel_x < X2) begin
      col = 2'd1; lx = pixel_x - X1; in_x = 1'b1;
    end else if (pixel_x >= X2 && pixel_x < X3) begin
      col = 2'd2; lx = pixel_x - X2; in_x = 1'b1;
    end
  end

  always_comb begin
    row  = 2'd0;
    ly   = 10'd0;
    in_y = 1'b0;
    if (pixel_y >= Y0 && pixel_y < Y1) begin
      row = 2'd0; ly = pixel_y - Y0; in_y = 1'b1;
    end else if (pixel_y >= Y1 && pixel_y < Y2) begin
      row = 2'd1; ly = pixel_y - Y1; in_y = 1'b1;
    end else if (pixel_y >= Y2 && pixel_y < Y3) begin
      row = 2'd2; ly = pixel_y - Y2; in_y = 1'b1;
    end
  end

  always_comb begin
    in_grid  = in_x && in_y;
    tile_idx = ({2'b00, row} * 4'd3) + {2'b00, col};
    val      = card_vals[{tile_idx, 2'b00} +: 4];
    face_up  = card_face_up[tile_idx];
    val_ok   = (val <= 4'd8);
    border   = (lx < BRD) || (lx >= BRD_R) || (ly < BRD) || (ly >= BRD_B);
    in_glyph = (lx >= GX_LO) && (lx < GX_HI) && (ly >= GY_LO) && (ly < GY_HI);
    gcol     = 5'((lx - GX_LO) >> 1);
    grow     = 5'((ly - GY_LO) >> 1);
    // tile_idx never exceeds 8, so cursor values 9..15 can never hit
    cur_hit  = in_grid && (cursor == tile_idx);
    rom_addr = (in_grid && in_glyph && val_ok) ? {val, grow} : 9'h000;
  end

  // stage 1 registers
  logic       s1_video_on, s1_in_grid, s1_border, s1_in_glyph;
  logic       s1_face_up, s1_val_ok, s1_cur_hit;
  logic [4:0] s1_gcol;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_video_on <= 1'b0;
      s1_in_grid  <= 1'b0;
      s1_border   <= 1'b0;
      s1_in_glyph <= 1'b0;
      s1_face_up  <= 1'b0;
      s1_val_ok   <= 1'b0;
      s1_cur_hit  <= 1'b0;
      s1_gcol     <= 5'd0;
    end else begin
      s1_video_on <= video_on;
      s1_in_grid  <= in_grid;
      s1_border   <= border;
      s1_in_glyph <= in_glyph;
      s1_face_up  <= face_up;
      s1_val_ok   <= val_ok;
      s1_cur_hit  <= cur_hit;
      s1_gcol     <= gcol;
    end
  end

  // cursor blink timebase
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // stage 2: glyph bit 23 is the leftmost column
  logic [4:0] bit_idx;
  logic       glyph_bit;

  always_comb begin
    bit_idx   = 5'd23 - s1_gcol;
    glyph_bit = rom_data[bit_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= 8'h00;
    end else if (!s1_video_on) begin
      rgb <= 8'h00;
    end else if (!s1_in_grid) begin
      rgb <= C_BG;
    end else if (s1_border) begin
      rgb <= (s1_cur_hit && !blink_phase) ? C_CUR : C_BG;
    end else if (!s1_face_up) begin
      rgb <= C_BACK;
    end else if (s1_in_glyph && s1_val_ok && glyph_bit) begin
      rgb <= C_FG;
    end else begin
      rgb <= C_FACE;
    end
  end

endmodule

// File: tb/tb_card_grid_renderer.sv
// tb/tb_card_grid_renderer.sv - directed-vector bench for card_grid_renderer
module tb_card_grid_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_tick;
  logic [35:0] card_vals;
  logic [8:0]  card_face_up;
  logic [3:0]  cursor;
  logic [8:0]  rom_addr;
  logic [23:0] rom_data;
  logic [7:0]  rgb;

  int n_pass  = 0;
  int n_total = 0;

  card_grid_renderer dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .card_vals(card_vals),
    .card_face_up(card_face_up), .cursor(cursor), .rom_addr(rom_addr),
    .rom_data(rom_data), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_card(input int idx, input logic [3:0] v, input logic up);
    card_vals[idx*4 +: 4] = v;
    card_face_up[idx]     = up;
  endtask

  // drive a pixel, capture rom_addr in stage 0, supply rom_data a clock later, capture rgb
  task automatic pix(input int x, input int y, input logic [23:0] rd,
                     output logic [8:0] addr, output logic [7:0] col);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    #1;
    addr = rom_addr;
    step();
    rom_data = rd;
    step();
    col = rgb;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    video_on = 1'b1;
    pixel_x = 10'd232;
    pixel_y = 10'd128;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (rgb !== 8'h00) $display("FAIL reset_rgb cyc%0d got %h want 00", i, rgb);
      else n_pass++;
    end
    reset = 1'b0;
    step();
    n_total++;
    if (rgb !== 8'h00) $display("FAIL refill_1clk got %h want 00", rgb);
    else n_pass++;
    step();
    n_total++;
    if (rgb !== 8'h03) $display("FAIL refill_2clk got %h want 03", rgb);
    else n_pass++;
  endtask

  task automatic test_glyph();
    logic [8:0] a;
    logic [7:0] c;
    set_card(0, 4'd3, 1'b1);
    pix(232, 128, 24'h1FFFF0, a, c);
    n_total++;
    if (a !== 9'h060) $display("FAIL glyph_addr got %h want 060", a);
    else n_pass++;
    n_total++;
    if (c !== 8'hFF) $display("FAIL glyph_bit23 got %h want FF", c);
    else n_pass++;
    pix(240, 128, 24'h1FFFF0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL glyph_bit19 got %h want 00", c);
    else n_pass++;
    pix(233, 131, 24'h000000, a, c);
    n_total++;
    if (a !== 9'h061) $display("FAIL glyph_addr_row1 got %h want 061", a);
    else n_pass++;
  endtask

  task automatic test_face_down();
    logic [8:0] a;
    logic [7:0] c;
    set_card(4, 4'd9, 1'b0);
    pix(320, 240, 24'hFFFFFF, a, c);
    n_total++;
    if (a !== 9'h000) $display("FAIL facedown_addr got %h want 000", a);
    else n_pass++;
    n_total++;
    if (c !== 8'h03) $display("FAIL facedown_rgb got %h want 03", c);
    else n_pass++;
    set_card(4, 4'd5, 1'b0);
    pix(320, 240, 24'hFFFFFF, a, c);
    n_total++;
    if (c !== 8'h03) $display("FAIL facedown_rgb_v5 got %h want 03", c);
    else n_pass++;
  endtask

  task automatic test_cursor_blink();
    logic [8:0] a;
    logic [7:0] c;
    cursor = 4'd0;
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'hFC) $display("FAIL cursor_on got %h want FC", c);
    else n_pass++;
    ticks(29);
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'hFC) $display("FAIL blink_29 got %h want FC", c);
    else n_pass++;
    ticks(1);
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL blink_30 got %h want 00", c);
    else n_pass++;
    ticks(30);
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'hFC) $display("FAIL blink_60 got %h want FC", c);
    else n_pass++;
    cursor = 4'd9;
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL cursor_none got %h want 00", c);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [8:0] a;
    logic [7:0] c;
    cursor = 4'd0;
    pix(223, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL left_of_grid got %h want 00", c);
    else n_pass++;
    pix(100, 100, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL outside got %h want 00", c);
    else n_pass++;
    cursor = 4'd8;
    pix(415, 359, 24'h0, a, c);
    n_total++;
    if (c !== 8'hFC) $display("FAIL tile8_corner_cur got %h want FC", c);
    else n_pass++;
    cursor = 4'd7;
    pix(415, 359, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL tile8_corner_nocur got %h want 00", c);
    else n_pass++;
    cursor = 4'd8;
    pix(416, 200, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL right_of_grid got %h want 00", c);
    else n_pass++;
    pix(413, 357, 24'h0, a, c);
    n_total++;
    if (c !== 8'h03) $display("FAIL tile8_inner got %h want 03", c);
    else n_pass++;
    video_on = 1'b0;
    pix(232, 128, 24'h000000, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL video_off got %h want 00", c);
    else n_pass++;
    video_on = 1'b1;
    cursor = 4'd9;
  endtask

  task automatic test_invalid_val();
    logic [8:0] a;
    logic [7:0] c;
    set_card(8, 4'd9, 1'b1);
    pix(360, 288, 24'hFFFFFF, a, c);
    n_total++;
    if (a !== 9'h000) $display("FAIL val9_addr got %h want 000", a);
    else n_pass++;
    n_total++;
    if (c !== 8'hFF) $display("FAIL val9_rgb got %h want FF", c);
    else n_pass++;
    pix(395, 340, 24'hFFFFFF, a, c);
    n_total++;
    if (c !== 8'hFF) $display("FAIL val9_rgb2 got %h want FF", c);
    else n_pass++;
  endtask

  task automatic test_reset_blink();
    logic [8:0] a;
    logic [7:0] c;
    cursor = 4'd0;
    ticks(30);
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL prereset_phase got %h want 00", c);
    else n_pass++;
    reset = 1'b1;
    frame_tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if (rgb !== 8'h00) $display("FAIL midframe_reset got %h want 00", rgb);
    else n_pass++;
    reset = 1'b0;
    frame_tick = 1'b0;
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'hFC) $display("FAIL phase_cleared got %h want FC", c);
    else n_pass++;
    ticks(29);
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'hFC) $display("FAIL cnt_cleared_29 got %h want FC", c);
    else n_pass++;
    ticks(1);
    pix(224, 120, 24'h0, a, c);
    n_total++;
    if (c !== 8'h00) $display("FAIL cnt_cleared_30 got %h want 00", c);
    else n_pass++;
  endtask

  initial begin
    reset        = 1'b1;
    pixel_x      = 10'd0;
    pixel_y      = 10'd0;
    video_on     = 1'b1;
    frame_tick   = 1'b0;
    card_vals    = 36'h0;
    card_face_up = 9'h000;
    cursor       = 4'd9;
    rom_data     = 24'h0;
    #1;
    test_reset();
    test_glyph();
    test_face_down();
    test_cursor_blink();
    test_boundaries();
    test_invalid_val();
    test_reset_blink();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
